adder_subtractor: RTL and testbench



---
 rtl/adder_subtractor_if.sv | 12 +
 rtl/adder_subtractor.sv | 48 ++++
 tb/tb_adder_subtractor.sv | 85 ++++++++
 3 files changed

// File: rtl/adder_subtractor_if.sv
// adder_subtractor_if: operand/mode inputs and registered result/flag outputs of the adder/subtractor.
interface adder_subtractor_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic [WIDTH-1:0] sum_or_diff;
    logic             cout_or_bout;
    logic             overflow;
    logic             zero;
    modport master (output a, b, en, input sum_or_diff, cout_or_bout, overflow, zero);
    modport slave  (input a, b, en, output sum_or_diff, cout_or_bout, overflow, zero);
endinterface

// File: rtl/adder_subtractor.sv
// adder_subtractor: registered ripple-carry two's-complement add (en=0) / subtract (en=1).
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module adder_subtractor #(parameter int WIDTH = 4) (
    input logic               clk,
    input logic               rst,
    adder_subtractor_if.slave bus
);
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    assign w_bx   = bus.b ^ {WIDTH{bus.en}};
    assign w_c[0] = bus.en;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (.i_a(bus.a[i]), .i_b(w_bx[i]), .i_c(w_c[i]), .o_s(w_s[i]), .o_c(w_c[i+1]));
    end
    // subtracting: final carry of A + ~B + 1 is the inverse of the borrow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[WIDTH] ^ bus.en;
            r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
            r_zero <= ~|w_s;
        end
    end
    assign bus.sum_or_diff  = r_sum;
    assign bus.cout_or_bout = r_cout;
    assign bus.overflow     = r_ovf;
    assign bus.zero         = r_zero;
endmodule

// File: tb/tb_adder_subtractor.sv
// tb_adder_subtractor: scoreboard bench; expected results queued at drive time, popped one cycle later.
module tb_adder_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    typedef struct {logic [3:0] s; logic c; logic v; logic z;} exp_t;
    exp_t q[$];
    adder_subtractor_if #(.WIDTH(4)) bus ();
    adder_subtractor #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic en, input logic r);
        exp_t m;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int res;
        int sres;
        if (r) begin
            m.s = 4'h0; m.c = 1'b0; m.v = 1'b0; m.z = 1'b0;
            return m;
        end
        res  = en ? ua - ub : ua + ub;
        sres = en ? sa - sb : sa + sb;
        m.s  = res[3:0];
        m.c  = en ? (ua < ub) : (res >= 16);
        m.v  = (sres > 7) || (sres < -8);
        m.z  = (res[3:0] == 4'h0);
        return m;
    endfunction
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b, input logic en, input logic r);
        exp_t e;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.en = en; rst = r;
        q.push_back(model(a, b, en, r));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
        end else begin
            e = q.pop_front();
            chk({tag, "_sum"}, int'(bus.sum_or_diff), int'(e.s));
            chk({tag, "_cout"}, int'(bus.cout_or_bout), int'(e.c));
            chk({tag, "_ovf"}, int'(bus.overflow), int'(e.v));
            chk({tag, "_zero"}, int'(bus.zero), int'(e.z));
        end
    endtask
    initial begin
        bus.a = 4'hF; bus.b = 4'hF; bus.en = 1'b0;
        step("rst0", 4'hF, 4'hF, 1'b0, 1'b1);
        step("rst1", 4'hF, 4'hF, 1'b0, 1'b1);
        step("rel", 4'hF, 4'hF, 1'b0, 1'b0);
        chk("rel_abs_sum", int'(bus.sum_or_diff), 14);
        step("add_1_7", 4'd1, 4'd7, 1'b0, 1'b0);
        chk("add_1_7_abs_ovf", int'(bus.overflow), 1);
        step("add_1_2", 4'd1, 4'd2, 1'b0, 1'b0);
        step("add_6_15", 4'd6, 4'd15, 1'b0, 1'b0);
        step("sub_13_6", 4'd13, 4'd6, 1'b1, 1'b0);
        step("sub_14_5", 4'd14, 4'd5, 1'b1, 1'b0);
        step("sub_6_12", 4'd6, 4'd12, 1'b1, 1'b0);
        chk("sub_6_12_abs_bout", int'(bus.cout_or_bout), 1);
        step("sub_0_1", 4'd0, 4'd1, 1'b1, 1'b0);
        step("sub_9_9", 4'd9, 4'd9, 1'b1, 1'b0);
        chk("sub_9_9_abs_zero", int'(bus.zero), 1);
        step("wrap_f_1", 4'hF, 4'h1, 1'b0, 1'b0);
        step("hold", 4'hF, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("alt", 4'd5, 4'd3, i[0], 1'b0);
        step("mid0", 4'd3, 4'd4, 1'b0, 1'b0);
        step("mid_rst", 4'd7, 4'd7, 1'b0, 1'b1);
        step("mid1", 4'd2, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++)
            step("rand", 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(15) == 0));
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
